// File: rtl/ysyx_25030085_mem_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
package ysyx_25030085_mem_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Master identifiers; also the bit positions in req/grant vectors.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Byte-strobe width for the default 32-bit data path.
  localparam int WMASK_W = 4;

endpackage

// File: rtl/ysyx_25030085_rr_pick.sv
// Two-input round-robin picker: with both requests active, the input that
// did not win last time is granted; a single request is granted directly.
module ysyx_25030085_rr_pick
  import ysyx_25030085_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant selection.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_IFU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_mem_arbiter.sv
// Shares one data-memory port between the IFU (read-only) and the LSU
// (read/write). One outstanding transaction, round-robin arbitration,
// registered request towards memory, response routed to the owner.
module ysyx_25030085_mem_arbiter
  import ysyx_25030085_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                ifu_req_valid,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_req_ready,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,

  input  logic                lsu_req_valid,
  input  logic                lsu_req_wen,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_req_ready,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,

  output logic                mem_req_valid,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic       last_owner;
  logic [1:0] req;
  logic [1:0] grant;
  logic       resp_fire;

  assign req = {lsu_req_valid, ifu_req_valid};

  ysyx_25030085_rr_pick u_pick (
    .req   (req),
    .last  (last_owner),
    .grant (grant)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, request handshakes and response routing.
  always_comb begin
    state_nxt      = state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    resp_fire      = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    lsu_resp_data  = '0;
    case (state)
      IDLE: begin
        // Ready is gated by rst_n so nothing is granted while reset is held.
        ifu_req_ready = rst_n & grant[OWN_IFU];
        lsu_req_ready = rst_n & grant[OWN_LSU];
        if (rst_n && (grant != 2'b00)) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          if (mem_resp_valid) begin
            // Zero-wait memory: accept and respond in the same cycle.
            resp_fire = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ifu_resp_valid = resp_fire && (owner == OWN_IFU);
    lsu_resp_valid = resp_fire && (owner == OWN_LSU);
    if (ifu_resp_valid) begin
      ifu_resp_data = mem_resp_data;
    end
    // A write acknowledge carries no data.
    if (lsu_resp_valid && !mem_req_wen) begin
      lsu_resp_data = mem_resp_data;
    end
  end

  // Latch the winning request, its owner and the round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner         <= OWN_IFU;
      last_owner    <= OWN_IFU;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else if (lsu_req_ready) begin
      owner         <= OWN_LSU;
      last_owner    <= OWN_LSU;
      mem_req_wen   <= lsu_req_wen;
      mem_req_addr  <= lsu_req_addr;
      mem_req_wdata <= lsu_req_wdata;
      mem_req_wmask <= lsu_req_wmask;
    end else if (ifu_req_ready) begin
      owner         <= OWN_IFU;
      last_owner    <= OWN_IFU;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= ifu_req_addr;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end
  end

endmodule
